// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch/decode/execute sequencer: opcodes, instruction
// field positions, FSM state encoding and small opcode-class helpers.
package fetch_sequencer_pkg;

  localparam logic [5:0] OP_ADD  = 6'd0;
  localparam logic [5:0] OP_SUB  = 6'd1;
  localparam logic [5:0] OP_AND  = 6'd2;
  localparam logic [5:0] OP_OR   = 6'd3;
  localparam logic [5:0] OP_XOR  = 6'd4;
  localparam logic [5:0] OP_LDI  = 6'd5;
  localparam logic [5:0] OP_TST  = 6'd6;
  localparam logic [5:0] OP_NOP  = 6'd7;
  localparam logic [5:0] OP_CEQ  = 6'd8;
  localparam logic [5:0] OP_CNE  = 6'd9;
  localparam logic [5:0] OP_CLT  = 6'd10;
  localparam logic [5:0] OP_CGE  = 6'd11;
  localparam logic [5:0] OP_CLTU = 6'd12;
  localparam logic [5:0] OP_CGEU = 6'd13;
  localparam logic [5:0] OP_BRT  = 6'd14;
  localparam logic [5:0] OP_BRF  = 6'd15;

  localparam int unsigned OP_MSB   = 31;
  localparam int unsigned OP_LSB   = 26;
  localparam int unsigned RA_MSB   = 25;
  localparam int unsigned RA_LSB   = 22;
  localparam int unsigned RB_MSB   = 21;
  localparam int unsigned RB_LSB   = 18;
  localparam int unsigned HL_BIT   = 17;
  localparam int unsigned RSVD_BIT = 16;
  localparam int unsigned VAL_MSB  = 15;
  localparam int unsigned VAL_LSB  = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_FAULT  = 3'd4
  } state_e;

  // Decoded instruction register; the reserved bit carries no meaning and is dropped.
  typedef struct packed {
    logic [5:0]  op;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic        highlow;
    logic [15:0] value;
  } instr_t;

  function automatic instr_t decode_word(input logic [31:0] w);
    instr_t d;
    d.op      = w[OP_MSB:OP_LSB];
    d.ra      = w[RA_MSB:RA_LSB];
    d.rb      = w[RB_MSB:RB_LSB];
    d.highlow = w[HL_BIT];
    d.value   = w[VAL_MSB:VAL_LSB];
    return d;
  endfunction

  function automatic logic op_is_valid(input logic [5:0] op);
    return op <= OP_BRF;
  endfunction

  function automatic logic op_writes_rf(input logic [5:0] op);
    return op <= OP_LDI;
  endfunction

  function automatic logic op_sets_flags(input logic [5:0] op);
    return (op >= OP_CEQ) && (op <= OP_CGEU);
  endfunction

endpackage

// File: rtl/fetch_sequencer_timeout_ctr.sv
// Counts consecutive un-acknowledged fetch cycles; tc_o flags the last allowed cycle.
module fetch_timeout_ctr #(
  parameter int unsigned LIMIT = 255,
  parameter int unsigned CW    = (LIMIT < 2) ? 1 : $clog2(LIMIT)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          inc_i,
  input  logic          ld_i,
  input  logic [CW-1:0] ld_val_i,
  output logic          tc_o
);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (ld_i) begin
      cnt_q <= ld_val_i;
    end else if (inc_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tc_o = (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/decode/execute control stage feeding the ALU and register file.
// One instruction in flight; FETCH -> DECODE -> EXEC, sticky FAULT on error.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter logic [31:0] PC_STEP       = 32'd1,
  parameter int unsigned FETCH_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [5:0]  alu_instr,
  output logic [15:0] alu_value,
  output logic        alu_highlow,
  output logic [3:0]  rf_ra_idx,
  output logic [3:0]  rf_rb_idx,
  output logic        alu_f1,
  output logic        alu_f2,
  input  logic        alu_f3,
  input  logic        alu_addrch,
  input  logic [31:0] alu_naddr,
  output logic        rf_we,
  output logic [3:0]  rf_wa,
  output logic [31:0] pc,
  output logic        busy,
  output logic        fault
);

  localparam int unsigned TCW = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT);

  state_e      state_q;
  logic [31:0] pc_q, pc_d;
  logic        f1_q, f2_q;
  instr_t      instr_q;
  logic        fields_en_q;
  logic        imem_req_q;
  logic        rf_we_q;
  logic        busy_q;
  logic        fault_q;
  logic        tmo_tc;
  logic        fetching;

  assign fetching = (state_q == ST_FETCH);

  fetch_timeout_ctr #(
    .LIMIT (FETCH_TIMEOUT),
    .CW    (TCW)
  ) u_timeout (
    .clk_i    (clock),
    .rst_ni   (reset_n),
    .clr_i    (!fetching || imem_ack),
    .inc_i    (fetching && !imem_ack),
    .ld_i     (1'b0),
    .ld_val_i ('0),
    .tc_o     (tmo_tc)
  );

  always_comb begin
    pc_d = alu_addrch ? alu_naddr : (pc_q + PC_STEP);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      f1_q        <= 1'b0;
      f2_q        <= 1'b0;
      instr_q     <= '0;
      fields_en_q <= 1'b0;
      imem_req_q  <= 1'b0;
      rf_we_q     <= 1'b0;
      busy_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      rf_we_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (run) begin
            state_q    <= ST_FETCH;
            imem_req_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (imem_ack) begin
            instr_q     <= decode_word(imem_rdata);
            fields_en_q <= 1'b1;
            imem_req_q  <= 1'b0;
            state_q     <= ST_DECODE;
          end else if (tmo_tc) begin
            imem_req_q <= 1'b0;
            busy_q     <= 1'b0;
            fault_q    <= 1'b1;
            state_q    <= ST_FAULT;
          end
        end
        ST_DECODE: begin
          if (!op_is_valid(instr_q.op)) begin
            fields_en_q <= 1'b0;
            busy_q      <= 1'b0;
            fault_q     <= 1'b1;
            state_q     <= ST_FAULT;
          end else begin
            // Write strobe is registered here so it is high for exactly the EXEC cycle.
            rf_we_q <= op_writes_rf(instr_q.op);
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          pc_q        <= pc_d;
          fields_en_q <= 1'b0;
          if (op_sets_flags(instr_q.op)) begin
            f2_q <= f1_q;
            f1_q <= alu_f3;
          end
          if (run) begin
            imem_req_q <= 1'b1;
            state_q    <= ST_FETCH;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_FAULT: begin
          state_q <= ST_FAULT;
        end
        default: begin
          imem_req_q  <= 1'b0;
          fields_en_q <= 1'b0;
          busy_q      <= 1'b0;
          fault_q     <= 1'b1;
          state_q     <= ST_FAULT;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_req_q ? pc_q : '0;
  assign alu_instr   = fields_en_q ? instr_q.op : '0;
  assign alu_value   = fields_en_q ? instr_q.value : '0;
  assign alu_highlow = fields_en_q & instr_q.highlow;
  assign rf_ra_idx   = fields_en_q ? instr_q.ra : '0;
  assign rf_rb_idx   = fields_en_q ? instr_q.rb : '0;
  assign alu_f1      = f1_q;
  assign alu_f2      = f2_q;
  assign rf_we       = rf_we_q;
  assign rf_wa       = rf_we_q ? instr_q.ra : '0;
  assign pc          = pc_q;
  assign busy        = busy_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: zero-wait memory model, hand-computed expectations.
module tb_fetch_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        run;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [5:0]  alu_instr;
  logic [15:0] alu_value;
  logic        alu_highlow;
  logic [3:0]  rf_ra_idx;
  logic [3:0]  rf_rb_idx;
  logic        alu_f1;
  logic        alu_f2;
  logic        alu_f3;
  logic        alu_addrch;
  logic [31:0] alu_naddr;
  logic        rf_we;
  logic [3:0]  rf_wa;
  logic [31:0] pc;
  logic        busy;
  logic        fault;

  logic [31:0] mem [16];
  logic        mem_en;
  logic [3:0]  mem_idx;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  assign mem_idx    = 4'(imem_addr);
  assign imem_ack   = imem_req & mem_en;
  assign imem_rdata = mem[mem_idx];

  fetch_sequencer #(
    .RESET_PC      (32'h0000_0000),
    .PC_STEP       (32'd1),
    .FETCH_TIMEOUT (4)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .run         (run),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .alu_instr   (alu_instr),
    .alu_value   (alu_value),
    .alu_highlow (alu_highlow),
    .rf_ra_idx   (rf_ra_idx),
    .rf_rb_idx   (rf_rb_idx),
    .alu_f1      (alu_f1),
    .alu_f2      (alu_f2),
    .alu_f3      (alu_f3),
    .alu_addrch  (alu_addrch),
    .alu_naddr   (alu_naddr),
    .rf_we       (rf_we),
    .rf_wa       (rf_wa),
    .pc          (pc),
    .busy        (busy),
    .fault       (fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [3:0] ra,
                                     input logic [3:0] rb, input logic hl,
                                     input logic [15:0] v);
    return {op, ra, rb, hl, 1'b0, v};
  endfunction

  initial begin
    reset_n    = 1'b0;
    run        = 1'b0;
    mem_en     = 1'b1;
    alu_f3     = 1'b0;
    alu_addrch = 1'b0;
    alu_naddr  = '0;
    for (int i = 0; i < 16; i++) mem[i] = mk(6'd7, 4'd0, 4'd0, 1'b0, 16'h0);
    mem[0]  = mk(6'd0,  4'd3, 4'd4, 1'b0, 16'h1234);
    mem[1]  = mk(6'd8,  4'd1, 4'd2, 1'b0, 16'h0000);
    mem[2]  = mk(6'd9,  4'd1, 4'd2, 1'b0, 16'h0000);
    mem[3]  = mk(6'd14, 4'd0, 4'd0, 1'b0, 16'h0040);
    mem[15] = mk(6'd7,  4'd1, 4'd2, 1'b1, 16'hBEEF);

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_req",   {31'd0, imem_req}, 32'd0);
    check("rst_pc",    pc, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_we",    {31'd0, rf_we}, 32'd0);
    check("rst_flags", {30'd0, alu_f2, alu_f1}, 32'd0);

    // Zero-wait ADD r3,r4: FETCH, DECODE, EXEC
    reset_n = 1'b1;
    run     = 1'b1;
    @(negedge clock);
    check("add_req",  {31'd0, imem_req}, 32'd1);
    check("add_addr", imem_addr, 32'd0);
    check("add_busy", {31'd0, busy}, 32'd1);
    @(negedge clock);
    check("add_ra",  {28'd0, rf_ra_idx}, 32'd3);
    check("add_rb",  {28'd0, rf_rb_idx}, 32'd4);
    check("add_val", {16'd0, alu_value}, 32'h1234);
    check("add_we_dec", {31'd0, rf_we}, 32'd0);
    @(negedge clock);
    check("add_we", {31'd0, rf_we}, 32'd1);
    check("add_wa", {28'd0, rf_wa}, 32'd3);
    check("add_pc_exec", pc, 32'd0);
    @(negedge clock);
    check("add_we_after", {31'd0, rf_we}, 32'd0);
    check("add_pc_next", pc, 32'd1);
    check("add_addr_next", imem_addr, 32'd1);

    // Flag shifting: op8 with f3=1, then op9 with f3=0
    @(negedge clock);
    alu_f3 = 1'b1;
    @(negedge clock);
    check("cmp1_op", {26'd0, alu_instr}, 32'd8);
    check("cmp1_we", {31'd0, rf_we}, 32'd0);
    @(negedge clock);
    check("cmp1_flags", {30'd0, alu_f2, alu_f1}, 32'd1);
    alu_f3 = 1'b0;
    repeat (3) @(negedge clock);
    check("cmp2_flags", {30'd0, alu_f2, alu_f1}, 32'd2);
    check("cmp2_pc", pc, 32'd3);

    // Branch to 0x40
    @(negedge clock);
    check("br_op", {26'd0, alu_instr}, 32'd14);
    alu_addrch = 1'b1;
    alu_naddr  = 32'h40;
    repeat (2) @(negedge clock);
    check("br_addr", imem_addr, 32'h40);
    check("br_flags", {30'd0, alu_f2, alu_f1}, 32'd2);
    alu_addrch = 1'b0;

    // Branch to 0xFFFF_FFFF, then sequential wrap to 0 with run dropped in EXEC
    @(negedge clock);
    alu_addrch = 1'b1;
    alu_naddr  = 32'hFFFF_FFFF;
    repeat (2) @(negedge clock);
    check("wrap_pc_top", pc, 32'hFFFF_FFFF);
    alu_addrch = 1'b0;
    @(negedge clock);
    check("nop_hl", {31'd0, alu_highlow}, 32'd1);
    @(negedge clock);
    check("nop_we", {31'd0, rf_we}, 32'd0);
    run = 1'b0;
    @(negedge clock);
    check("wrap_pc", pc, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_req", {31'd0, imem_req}, 32'd0);
    @(negedge clock);
    check("idle_stay", {31'd0, busy}, 32'd0);

    // Illegal opcode 20
    mem[0] = mk(6'd20, 4'd5, 4'd6, 1'b0, 16'h0);
    run    = 1'b1;
    repeat (2) @(negedge clock);
    check("ill_op", {26'd0, alu_instr}, 32'd20);
    check("ill_we_dec", {31'd0, rf_we}, 32'd0);
    @(negedge clock);
    check("ill_fault", {31'd0, fault}, 32'd1);
    check("ill_busy", {31'd0, busy}, 32'd0);
    check("ill_req", {31'd0, imem_req}, 32'd0);
    check("ill_pc", pc, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("ill_sticky", {30'd0, fault, rf_we}, 32'd2);
    end

    // Fetch timeout with FETCH_TIMEOUT=4
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    check("tmo_clr", {31'd0, fault}, 32'd0);
    mem_en = 1'b0;
    run    = 1'b1;
    repeat (4) @(negedge clock);
    check("tmo_req4", {31'd0, imem_req}, 32'd1);
    check("tmo_nofault4", {31'd0, fault}, 32'd0);
    @(negedge clock);
    check("tmo_fault", {31'd0, fault}, 32'd1);
    check("tmo_req", {31'd0, imem_req}, 32'd0);
    check("tmo_busy", {31'd0, busy}, 32'd0);
    mem_en = 1'b1;
    repeat (3) @(negedge clock);
    check("tmo_sticky", {31'd0, fault}, 32'd1);

    // Asynchronous reset while a fetch is outstanding at pc=5 with F1=1
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    mem[0]  = mk(6'd8, 4'd0, 4'd0, 1'b0, 16'h0);
    alu_f3  = 1'b1;
    run     = 1'b1;
    repeat (2) @(negedge clock);
    alu_addrch = 1'b1;
    alu_naddr  = 32'd5;
    @(negedge clock);
    mem_en = 1'b0;
    @(negedge clock);
    alu_addrch = 1'b0;
    check("mid_req", {31'd0, imem_req}, 32'd1);
    check("mid_addr", imem_addr, 32'd5);
    check("mid_f1", {31'd0, alu_f1}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("arst_req", {31'd0, imem_req}, 32'd0);
    check("arst_pc", pc, 32'd0);
    check("arst_fault", {31'd0, fault}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_flags", {30'd0, alu_f2, alu_f1}, 32'd0);
    check("arst_addr", imem_addr, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
